addsub_serial: RTL and testbench

Parametrised, digit-serial adder/subtractor, successor to the fixed 4-bit combinational subtractor. It processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, under a start/busy/done handshake. It supports add and subtract modes with carry/borrow in and out, plus signed overflow. It is the arithmetic datapath block for the multi-cycle units that follow in this chapter.

---
 rtl/addsub_serial_pkg.sv | 6 +
 rtl/addsub_serial_digit.sv | 27 ++
 rtl/addsub_serial.sv | 103 ++++++++++
 tb/tb_addsub_serial.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/addsub_serial_pkg.sv
// addsub_serial_pkg: shared mode and state encodings for the digit-serial adder/subtractor
package addsub_serial_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/addsub_serial_digit.sv
// addsub_digit: combinational DIGIT-bit ripple slice; b is inverted in subtract mode
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  input  logic             sub,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb
);
  logic [DIGIT-1:0] bx;
  logic c;
  assign bx = b_d ^ {DIGIT{sub}};
  always_comb begin
    c = cin;
    c_msb = cin;
    s_d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = c;
      s_d[i] = a_d[i] ^ bx[i] ^ c;
      c = (a_d[i] & bx[i]) | (c & (a_d[i] ^ bx[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial add/subtract, LSB digit first, start/busy/done handshake
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             sub_q, sub_d, c_q, c_d, co_q, co_d, ov_q, ov_d, done_q, done_d;
  logic [DIGIT-1:0] sl_s;
  logic             sl_c, sl_m;
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d  (a_q[DIGIT-1:0]),
    .b_d  (b_q[DIGIT-1:0]),
    .cin  (c_q),
    .sub  (sub_q),
    .s_d  (sl_s),
    .cout (sl_c),
    .c_msb(sl_m)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sub_d   = sub_q;
    c_d     = c_q;
    co_d    = co_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_RUN;
        cnt_d   = '0;
        a_d     = a;
        b_d     = b;
        sub_d   = sub;
        c_d     = (sub == MODE_SUB) ? ~ci : ci;
      end
    end else begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      // result slices enter from the MSB side so the word is aligned after N steps
      s_d   = WIDTH'({sl_s, s_q} >> DIGIT);
      c_d   = sl_c;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        co_d    = sl_c ^ sub_q;
        ov_d    = sl_c ^ sl_m;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end
  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
  assign ov   = ov_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: scoreboard bench for two configurations (4x1 and 8x4) against an arithmetic model
module tb_addsub_serial;
  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st4 = 1'b0, sub4 = 1'b0, ci4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic busy4, done4, co4, ov4;
  logic [3:0] s4;
  logic st8 = 1'b0, sub8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8, done8, co8, ov8;
  logic [7:0] s8;
  exp_t q4[$], q8[$];
  exp_t e4, e8;
  int compared = 0, mismatched = 0;
  logic last_done4 = 1'b0;
  always #5 clk = ~clk;
  addsub_serial #(.WIDTH(4), .DIGIT(1)) u4 (
    .clk(clk), .rst(rst), .start(st4), .sub(sub4), .ci(ci4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .s(s4), .co(co4), .ov(ov4)
  );
  addsub_serial #(.WIDTH(8), .DIGIT(4)) u8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub8), .ci(ci8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .s(s8), .co(co8), .ov(ov8)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask
  // true integer arithmetic; results reduced to w bits afterwards
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic sb, input logic c);
    exp_t e;
    longint m  = longint'(1) << w;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = a[w-1] ? ua - m : ua;
    longint sv = b[w-1] ? ub - m : ub;
    longint r  = sb ? ua - ub - longint'(c) : ua + ub + longint'(c);
    longint sr = sb ? sa - sv - longint'(c) : sa + sv + longint'(c);
    e.s  = 8'(((r % m) + m) % m);
    e.co = sb ? (ua < ub + longint'(c)) : (r >= m);
    e.ov = (sr < -(m / 2)) || (sr >= m / 2);
    return e;
  endfunction
  task automatic wait_idle4();
    int n = 0;
    while (busy4 && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) fail("timeout4");
  endtask
  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) fail("timeout8");
  endtask
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic sb, input logic c);
    wait_idle4();
    last_done4 = done4;
    st4 = 1'b1; a4 = a; b4 = b; sub4 = sb; ci4 = c;
    q4.push_back(model(4, {4'b0, a}, {4'b0, b}, sb, c));
    @(negedge clk);
    st4 = 1'b0;
  endtask
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sb, input logic c);
    wait_idle8();
    st8 = 1'b1; a8 = a; b8 = b; sub8 = sb; ci8 = c;
    q8.push_back(model(8, a, b, sb, c));
    @(negedge clk);
    st8 = 1'b0;
  endtask
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) fail("done4_unexpected");
      else begin
        e4 = q4.pop_front();
        chk("s4", 32'(s4), 32'(e4.s[3:0]));
        chk("co4", 32'(co4), 32'(e4.co));
        chk("ov4", 32'(ov4), 32'(e4.ov));
      end
    end
    if (done8) begin
      if (q8.size() == 0) fail("done8_unexpected");
      else begin
        e8 = q8.pop_front();
        chk("s8", 32'(s8), 32'(e8.s));
        chk("co8", 32'(co8), 32'(e8.co));
        chk("ov8", 32'(ov8), 32'(e8.ov));
      end
    end
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_s", 32'(s4), 0);
    chk("rst_co", 32'(co4), 0);
    chk("rst_ov", 32'(ov4), 0);
    chk("rst_busy8", 32'(busy8), 0);
    rst = 1'b0;
    @(negedge clk);
    issue4(4'b0001, 4'b0001, 1'b1, 1'b0);
    n = 0;
    while (busy4 && n < 50) begin n++; @(negedge clk); end
    chk("busy_len4", 32'(n), 4);
    chk("done_at_end4", 32'(done4), 1);
    @(negedge clk);
    chk("done_pulse4", 32'(done4), 0);
    issue4(4'b0001, 4'b0001, 1'b1, 1'b1);
    wait_idle4();
    repeat (3) @(negedge clk);
    chk("hold_s4", 32'(s4), 32'hF);
    chk("hold_co4", 32'(co4), 1);
    issue4(4'b1000, 4'b0111, 1'b1, 1'b0);
    issue4(4'b1000, 4'b0111, 1'b1, 1'b1);
    chk("b2b_done", 32'(last_done4), 1);
    chk("b2b_busy", 32'(busy4), 1);
    issue4(4'b0110, 4'b0011, 1'b0, 1'b1);
    st4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; sub4 = 1'b1; ci4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0; a4 = 4'b1010; b4 = 4'b0101; sub4 = 1'b0;
    wait_idle4();
    repeat (4) @(negedge clk);
    chk("ignored_idle", 32'(busy4), 0);
    issue4(4'b0101, 4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_done", 32'(done4), 0);
    chk("abort_s", 32'(s4), 0);
    chk("abort_co", 32'(co4), 0);
    chk("abort_ov", 32'(ov4), 0);
    q4.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    issue4(4'b0111, 4'b0001, 1'b0, 1'b0);
    wait_idle4();
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);
    n = 0;
    while (busy8 && n < 50) begin n++; @(negedge clk); end
    chk("busy_len8", 32'(n), 2);
    issue8(8'h7F, 8'h01, 1'b0, 1'b0);
    issue8(8'h80, 8'h01, 1'b1, 1'b0);
    issue8(8'h00, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      issue4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle4();
    wait_idle8();
    repeat (3) @(negedge clk);
    chk("drain4", 32'(q4.size()), 0);
    chk("drain8", 32'(q8.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
